ffq_buzzer_arbiter: RTL

//  Front end of the fastest-finger-first quiz. Synchronises and debounces the player buttons and

---
 rtl/ffq_buzzer_arbiter_pkg.sv | 28 ++
 rtl/ffq_buzzer_arbiter_debounce.sv | 54 +++++
 rtl/ffq_buzzer_arbiter.sv | 138 +++++++++++++
 3 files changed

// File: rtl/ffq_buzzer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ffq_buzzer_arbiter_pkg
// Description : Shared state codes, digit codes and sizing helper for the
//               fastest-finger-first buzzer front end.
// Revision    : 1.0 - initial release
// ============================================================================
package ffq_buzzer_arbiter_pkg;

  // Round state of the arbiter
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // Codes shown on the 7-segment display outside the LOCKED state
  localparam logic [3:0] DIGIT_IDLE    = 4'h0;
  localparam logic [3:0] DIGIT_TIMEOUT = 4'hE;

  // Width of a player index; a single player still needs one bit
  function automatic int winner_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ffq_buzzer_arbiter_debounce.sv
`default_nettype none
// ============================================================================
// Module      : ffq_buzzer_arbiter_debounce
// Description : Two-flop synchroniser followed by a stable-count debouncer
//               for a single raw asynchronous button.
// Revision    : 1.0 - initial release
// ============================================================================
module ffq_buzzer_arbiter_debounce
  import ffq_buzzer_arbiter_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic db_o
);

  localparam int             CW      = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYC);

  logic          sync1_q;
  logic          sync2_q;
  logic          db_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, then flip the level once the input has disagreed long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      db_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q != db_q) begin
        if (cnt_q == CNT_MAX) begin
          db_q  <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        // Any bounce back to the current level restarts the stability window
        cnt_q <= '0;
      end
    end
  end

  assign db_o = db_q;

endmodule
`default_nettype wire

// File: rtl/ffq_buzzer_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ffq_buzzer_arbiter
// Description : Buzzer front end: debounces player buttons, arbitrates the
//               first unblocked press of an armed round, latches the winner
//               and drives a registered hex digit for the 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module ffq_buzzer_arbiter
  import ffq_buzzer_arbiter_pkg::*;
#(
  parameter int N_PLAYERS    = 4,
  parameter int DEBOUNCE_CYC = 16,
  parameter int TIMEOUT_CYC  = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 clear_i,
  input  logic [N_PLAYERS-1:0] btn_i,
  output logic [3:0]           digit_o,
  output logic                 winner_valid_o,
  output logic                 armed_o,
  output logic                 timeout_o,
  output logic                 buzz_o
);

  localparam int            WW        = winner_width(N_PLAYERS);
  localparam int            TW        = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

  logic [N_PLAYERS-1:0] db;
  logic [N_PLAYERS-1:0] db_q;
  logic [N_PLAYERS-1:0] block_q, block_d;
  logic [N_PLAYERS-1:0] press;
  logic                 any_press;
  logic [WW-1:0]        win_idx;
  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [WW-1:0]        winner_q, winner_d;
  logic [3:0]           digit_d;
  logic                 winner_valid_d, armed_d, timeout_d, buzz_d;

  generate
    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_btn
      ffq_buzzer_arbiter_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
      ) u_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn_i (btn_i[i]),
        .db_o  (db[i])
      );
    end
  endgenerate

  // Rising edge of each debounced level, masked by buttons held at arming
  assign press     = db & ~db_q & ~block_q;
  assign any_press = |press;

  // Priority encoder: the lowest-numbered pressing player wins a tie
  always_comb begin
    win_idx = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (press[i]) win_idx = WW'(i);
    end
  end

  // Next-state, block mask, timeout counter and next registered outputs
  always_comb begin
    state_d  = state_q;
    block_d  = block_q & db;
    tcnt_d   = tcnt_q;
    winner_d = winner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !clear_i) begin
          state_d = ST_ARMED;
          block_d = db;
          tcnt_d  = '0;
        end
      end
      ST_ARMED: begin
        if (clear_i) begin
          state_d = ST_IDLE;
        end else if (any_press) begin
          state_d  = ST_LOCKED;
          winner_d = win_idx;
        end else if (tcnt_q == TCNT_LAST) begin
          state_d = ST_TIMEOUT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_LOCKED, ST_TIMEOUT: begin
        if (clear_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    digit_d        = DIGIT_IDLE;
    winner_valid_d = (state_d == ST_LOCKED);
    armed_d        = (state_d == ST_ARMED);
    timeout_d      = (state_d == ST_TIMEOUT);
    buzz_d         = (state_q == ST_ARMED) && (state_d == ST_LOCKED);
    if (state_d == ST_LOCKED)  digit_d = 4'(winner_d) + 4'd1;
    if (state_d == ST_TIMEOUT) digit_d = DIGIT_TIMEOUT;
  end

  // State, arbitration bookkeeping and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      db_q           <= '0;
      block_q        <= '0;
      tcnt_q         <= '0;
      winner_q       <= '0;
      digit_o        <= DIGIT_IDLE;
      winner_valid_o <= 1'b0;
      armed_o        <= 1'b0;
      timeout_o      <= 1'b0;
      buzz_o         <= 1'b0;
    end else begin
      state_q        <= state_d;
      db_q           <= db;
      block_q        <= block_d;
      tcnt_q         <= tcnt_d;
      winner_q       <= winner_d;
      digit_o        <= digit_d;
      winner_valid_o <= winner_valid_d;
      armed_o        <= armed_d;
      timeout_o      <= timeout_d;
      buzz_o         <= buzz_d;
    end
  end

endmodule
`default_nettype wire
